// File: rtl/cmul_sequencer.sv
// cmul_sequencer: shares one FP32 multiplier across the four real products
// of a complex multiply a*b (a = data, b = twiddle). Products come back as
// rr/ii/ri/ir for the butterfly add/sub stage (re = rr-ii, im = ri+ir).
// MUL_LAT is the multiplier latency in cycles (0 = combinational multiplier).
// Optional feature macro: CMUL_UNITY_BYPASS_EN (skips the multiplier when
// the twiddle is exactly 1+0j).
//
// state  | meaning
// IDLE   | in_ready high, waiting for an operand pair
// ISSUE  | one product per cycle to the multiplier, index k = 0..3
// DRAIN  | issues done, waiting for the k=3 product to come back
// HOLD   | out_valid high, products held until out_ready
module cmul_sequencer #(
  parameter int MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_re,
  input  logic [31:0] a_im,
  input  logic [31:0] b_re,
  input  logic [31:0] b_im,
  output logic        mul_en,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] p_rr,
  output logic [31:0] p_ii,
  output logic [31:0] p_ri,
  output logic [31:0] p_ir
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_HOLD} state_t;

  state_t      state;
  logic [1:0]  k;
  logic [31:0] ra_re, ra_im, rb_re, rb_im;
  logic        cap_v;
  logic [1:0]  cap_idx;
  logic        cap3;

  // Operand pair for product index: rr, ii, ri, ir
  function automatic logic [63:0] sel_ops(input logic [1:0] idx,
                                          input logic [31:0] are, aim, bre, bim);
    case (idx)
      2'd0:    sel_ops = {are, bre};
      2'd1:    sel_ops = {aim, bim};
      2'd2:    sel_ops = {are, bim};
      default: sel_ops = {aim, bre};
    endcase
  endfunction

  generate
    if (MUL_LAT == 0) begin : g_nopipe
      assign cap_v   = mul_en;
      assign cap_idx = k;
    end else begin : g_pipe
      logic [MUL_LAT-1:0] tag_v;
      logic [1:0]         tag_i [MUL_LAT];
      // Tag pipe follows each issue through the multiplier; cleared on reset
      // so in-flight products of an aborted transaction are never captured.
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_v <= '0;
          for (int i = 0; i < MUL_LAT; i++) tag_i[i] <= 2'd0;
        end else begin
          tag_v[0] <= mul_en;
          tag_i[0] <= k;
          for (int i = 1; i < MUL_LAT; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_i[i] <= tag_i[i-1];
          end
        end
      end
      assign cap_v   = tag_v[MUL_LAT-1];
      assign cap_idx = tag_i[MUL_LAT-1];
    end
  endgenerate

  assign cap3 = cap_v && (cap_idx == 2'd3);

  // Sequencer FSM with registered handshake, multiplier and product outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= 2'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      mul_en    <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      p_rr      <= '0;
      p_ii      <= '0;
      p_ri      <= '0;
      p_ir      <= '0;
      ra_re     <= '0;
      ra_im     <= '0;
      rb_re     <= '0;
      rb_im     <= '0;
    end else begin
      if (cap_v) begin
        case (cap_idx)
          2'd0:    p_rr <= mul_p;
          2'd1:    p_ii <= mul_p;
          2'd2:    p_ri <= mul_p;
          default: p_ir <= mul_p;
        endcase
      end
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            ra_re    <= a_re;
            ra_im    <= a_im;
            rb_re    <= b_re;
            rb_im    <= b_im;
`ifdef CMUL_UNITY_BYPASS_EN
            if (b_re == 32'h3F80_0000 && b_im == 32'h0000_0000) begin
              p_rr      <= a_re;
              p_ii      <= {a_im[31], 31'd0};
              p_ri      <= {a_re[31], 31'd0};
              p_ir      <= a_im;
              out_valid <= 1'b1;
              state     <= S_HOLD;
            end else
`endif
            begin
              state  <= S_ISSUE;
              k      <= 2'd0;
              mul_en <= 1'b1;
              mul_a  <= a_re;
              mul_b  <= b_re;
            end
          end
        end
        S_ISSUE: begin
          if (k == 2'd3) begin
            mul_en <= 1'b0;
            mul_a  <= '0;
            mul_b  <= '0;
            k      <= 2'd0;
            // With a combinational multiplier the last product lands now
            if (cap3) begin
              out_valid <= 1'b1;
              state     <= S_HOLD;
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            k <= k + 2'd1;
            {mul_a, mul_b} <= sel_ops(k + 2'd1, ra_re, ra_im, rb_re, rb_im);
          end
        end
        S_DRAIN: begin
          if (cap3) begin
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmul_sequencer.sv
// Directed bench for cmul_sequencer: three instances (MUL_LAT 0, 1, 3) driven
// by shared stimulus, each with a behavioural table-lookup multiplier of the
// matching latency.
module tb_cmul_sequencer;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] a_re, a_im, b_re, b_im;

  logic        in_ready_w [3];
  logic        mul_en_w   [3];
  logic        out_valid_w[3];
  logic [31:0] mul_a_w [3];
  logic [31:0] mul_b_w [3];
  logic [31:0] mul_p_w [3];
  logic [31:0] p_rr_w  [3];
  logic [31:0] p_ii_w  [3];
  logic [31:0] p_ri_w  [3];
  logic [31:0] p_ir_w  [3];

  int n_pass = 0, n_fail = 0, n_tot = 0;

  always #5 clk = ~clk;

  cmul_sequencer #(.MUL_LAT(0)) u_l0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .mul_en(mul_en_w[0]), .mul_a(mul_a_w[0]), .mul_b(mul_b_w[0]), .mul_p(mul_p_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .p_rr(p_rr_w[0]), .p_ii(p_ii_w[0]), .p_ri(p_ri_w[0]), .p_ir(p_ir_w[0]));

  cmul_sequencer #(.MUL_LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .mul_en(mul_en_w[1]), .mul_a(mul_a_w[1]), .mul_b(mul_b_w[1]), .mul_p(mul_p_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .p_rr(p_rr_w[1]), .p_ii(p_ii_w[1]), .p_ri(p_ri_w[1]), .p_ir(p_ir_w[1]));

  cmul_sequencer #(.MUL_LAT(3)) u_l3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .mul_en(mul_en_w[2]), .mul_a(mul_a_w[2]), .mul_b(mul_b_w[2]), .mul_p(mul_p_w[2]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .p_rr(p_rr_w[2]), .p_ii(p_ii_w[2]), .p_ri(p_ri_w[2]), .p_ir(p_ir_w[2]));

  // Hand-computed FP32 products for every operand pair the bench uses
  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    case ({x, y})
      64'h40000000_3F000000: fmul = 32'h3F800000;
      64'h40400000_40800000: fmul = 32'h41400000;
      64'h40000000_40800000: fmul = 32'h41000000;
      64'h40400000_3F000000: fmul = 32'h3FC00000;
      64'h3F800000_40000000: fmul = 32'h40000000;
      64'hC0A00000_3F800000: fmul = 32'hC0A00000;
      64'h40000000_00000000: fmul = 32'h00000000;
      64'hC0A00000_00000000: fmul = 32'h80000000;
      64'h40000000_3F800000: fmul = 32'h40000000;
      64'h00000000_00000000: fmul = 32'h00000000;
      default:               fmul = 32'hDEADBEEF;
    endcase
  endfunction

  function automatic int lat_of(input int j);
    return (j == 0) ? 0 : (j == 1) ? 1 : 3;
  endfunction

  logic [31:0] mp1;
  logic [31:0] mp3 [3];
  assign mul_p_w[0] = fmul(mul_a_w[0], mul_b_w[0]);
  assign mul_p_w[1] = mp1;
  assign mul_p_w[2] = mp3[2];
  always @(posedge clk) begin
    mp1    <= fmul(mul_a_w[1], mul_b_w[1]);
    mp3[0] <= fmul(mul_a_w[2], mul_b_w[2]);
    mp3[1] <= mp3[0];
    mp3[2] <= mp3[1];
  end

  // Event monitor: accepts, issues, out_valid rise latency, handshakes
  int          cyc = 0;
  int          acc_n[3], en_n[3], hs_n[3], lat_last[3];
  int          acc_log[3][64];
  logic [31:0] hs_rr[3], hs_ii[3], hs_ri[3], hs_ir[3];
  logic        ov_prev[3];
  always @(posedge clk) begin
    for (int j = 0; j < 3; j++) begin
      if (in_valid && in_ready_w[j]) begin
        if (acc_n[j] < 64) acc_log[j][acc_n[j]] = cyc;
        acc_n[j]++;
      end
      if (mul_en_w[j]) en_n[j]++;
      if (out_valid_w[j] && !ov_prev[j] && acc_n[j] > 0 && acc_n[j] <= 64)
        lat_last[j] = cyc - acc_log[j][acc_n[j]-1];
      if (out_valid_w[j] && out_ready) begin
        hs_n[j]++;
        hs_rr[j] = p_rr_w[j];
        hs_ii[j] = p_ii_w[j];
        hs_ri[j] = p_ri_w[j];
        hs_ir[j] = p_ir_w[j];
      end
      ov_prev[j] = out_valid_w[j];
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tot++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic send(input logic [31:0] ar, ai, br, bi);
    @(negedge clk);
    in_valid = 1'b1;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    @(negedge clk);
    in_valid = 1'b0;
    a_re = 32'h7F7F7F7F; a_im = 32'h7F7F7F7F; b_re = 32'h7F7F7F7F; b_im = 32'h7F7F7F7F;
  endtask

  task automatic wait_hs(input int b0, input int b1, input int b2);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (hs_n[0] > b0 && hs_n[1] > b1 && hs_n[2] > b2) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("hs_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (in_ready_w[0] && in_ready_w[1] && in_ready_w[2] &&
          !out_valid_w[0] && !out_valid_w[1] && !out_valid_w[2]) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_prod(input string tn, input int j,
                          input logic [31:0] rr, ii, ri, ir);
    check($sformatf("%s_L%0d_rr", tn, lat_of(j)), hs_rr[j], rr);
    check($sformatf("%s_L%0d_ii", tn, lat_of(j)), hs_ii[j], ii);
    check($sformatf("%s_L%0d_ri", tn, lat_of(j)), hs_ri[j], ri);
    check($sformatf("%s_L%0d_ir", tn, lat_of(j)), hs_ir[j], ir);
  endtask

  initial begin
    int hb[3], eb[3], ab[3];
    logic all_ov;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;

    // Reset state
    repeat (3) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("rst_in_ready_L%0d", lat_of(j)), {31'd0, in_ready_w[j]}, 32'd0);
      check($sformatf("rst_out_valid_L%0d", lat_of(j)), {31'd0, out_valid_w[j]}, 32'd0);
      check($sformatf("rst_mul_en_L%0d", lat_of(j)), {31'd0, mul_en_w[j]}, 32'd0);
      check($sformatf("rst_mul_a_L%0d", lat_of(j)), mul_a_w[j], 32'd0);
      check($sformatf("rst_p_rr_L%0d", lat_of(j)), p_rr_w[j], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 3; j++)
      check($sformatf("post_rst_in_ready_L%0d", lat_of(j)), {31'd0, in_ready_w[j]}, 32'd1);

    // Basic transaction and latency sweep
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin hb[j] = hs_n[j]; eb[j] = en_n[j]; end
    send(32'h40000000, 32'h40400000, 32'h3F000000, 32'h40800000);
    wait_hs(hb[0], hb[1], hb[2]);
    for (int j = 0; j < 3; j++) begin
      chk_prod("basic", j, 32'h3F800000, 32'h41400000, 32'h41000000, 32'h3FC00000);
      check($sformatf("basic_lat_L%0d", lat_of(j)), lat_last[j], 5 + lat_of(j));
      check($sformatf("basic_mul_en_L%0d", lat_of(j)), en_n[j] - eb[j], 32'd4);
    end
    wait_idle();

    // Backpressure: out_ready low for 10 cycles once all products are valid
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) hb[j] = hs_n[j];
    send(32'h40000000, 32'h40400000, 32'h3F000000, 32'h40800000);
    all_ov = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid_w[0] && out_valid_w[1] && out_valid_w[2]) begin
        all_ov = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("bp_valid_timeout", {31'd0, all_ov}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        check($sformatf("bp_out_valid_L%0d", lat_of(j)), {31'd0, out_valid_w[j]}, 32'd1);
        check($sformatf("bp_in_ready_L%0d", lat_of(j)), {31'd0, in_ready_w[j]}, 32'd0);
        check($sformatf("bp_p_rr_L%0d", lat_of(j)), p_rr_w[j], 32'h3F800000);
        check($sformatf("bp_p_ir_L%0d", lat_of(j)), p_ir_w[j], 32'h3FC00000);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("bp_rel_in_ready_L%0d", lat_of(j)), {31'd0, in_ready_w[j]}, 32'd1);
      check($sformatf("bp_rel_out_valid_L%0d", lat_of(j)), {31'd0, out_valid_w[j]}, 32'd0);
      check($sformatf("bp_hs_count_L%0d", lat_of(j)), hs_n[j] - hb[j], 32'd1);
    end

    // Back-to-back with in_valid held high for 40 cycles
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin hb[j] = hs_n[j]; eb[j] = en_n[j]; ab[j] = acc_n[j]; end
    @(negedge clk);
    in_valid = 1'b1;
    a_re = 32'h40000000; a_im = 32'h40400000; b_re = 32'h3F000000; b_im = 32'h40800000;
    repeat (40) @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    for (int j = 0; j < 3; j++) begin
      int na;
      na = acc_n[j] - ab[j];
      check($sformatf("b2b_accepts_L%0d", lat_of(j)), na, 39 / (6 + lat_of(j)) + 1);
      for (int i = ab[j] + 1; i < acc_n[j] && i < 64; i++)
        check($sformatf("b2b_spacing_L%0d", lat_of(j)),
              acc_log[j][i] - acc_log[j][i-1], 6 + lat_of(j));
      check($sformatf("b2b_hs_L%0d", lat_of(j)), hs_n[j] - hb[j], na);
      check($sformatf("b2b_mul_en_L%0d", lat_of(j)), en_n[j] - eb[j], 4 * na);
      chk_prod("b2b", j, 32'h3F800000, 32'h41400000, 32'h41000000, 32'h3FC00000);
    end

    // Reset in the cycle of the k=2 issue, then a fresh transaction
    for (int j = 0; j < 3; j++) hb[j] = hs_n[j];
    send(32'h40000000, 32'h40400000, 32'h3F000000, 32'h40800000);
    @(negedge clk);
    @(negedge clk);
    check("mid_k2_mul_en_L3", {31'd0, mul_en_w[2]}, 32'd1);
    check("mid_k2_mul_a_L3", mul_a_w[2], 32'h40000000);
    check("mid_k2_mul_b_L3", mul_b_w[2], 32'h40800000);
    rst = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("mid_rst_mul_en_L%0d", lat_of(j)), {31'd0, mul_en_w[j]}, 32'd0);
      check($sformatf("mid_rst_mul_b_L%0d", lat_of(j)), mul_b_w[j], 32'd0);
      check($sformatf("mid_rst_in_ready_L%0d", lat_of(j)), {31'd0, in_ready_w[j]}, 32'd0);
      check($sformatf("mid_rst_p_ii_L%0d", lat_of(j)), p_ii_w[j], 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 3; j++)
      check($sformatf("mid_rel_in_ready_L%0d", lat_of(j)), {31'd0, in_ready_w[j]}, 32'd1);
    send(32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000);
    wait_hs(hb[0], hb[1], hb[2]);
    for (int j = 0; j < 3; j++) begin
      chk_prod("after_rst", j, 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
      check($sformatf("after_rst_hs_L%0d", lat_of(j)), hs_n[j] - hb[j], 32'd1);
    end
    wait_idle();

    // Unity twiddle
    for (int j = 0; j < 3; j++) begin hb[j] = hs_n[j]; eb[j] = en_n[j]; end
    send(32'hC0A00000, 32'h40000000, 32'h3F800000, 32'h00000000);
    wait_hs(hb[0], hb[1], hb[2]);
    for (int j = 0; j < 3; j++) begin
      chk_prod("unity", j, 32'hC0A00000, 32'h00000000, 32'h80000000, 32'h40000000);
`ifdef CMUL_UNITY_BYPASS_EN
      check($sformatf("unity_lat_L%0d", lat_of(j)), lat_last[j], 32'd1);
      check($sformatf("unity_mul_en_L%0d", lat_of(j)), en_n[j] - eb[j], 32'd0);
`else
      check($sformatf("unity_lat_L%0d", lat_of(j)), lat_last[j], 5 + lat_of(j));
      check($sformatf("unity_mul_en_L%0d", lat_of(j)), en_n[j] - eb[j], 32'd4);
`endif
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
